// File: rtl/alu_mc_if.sv
// Request/response bundle between the execute-stage issue logic and the multi-cycle ALU.
interface alu_mc_if #(
    parameter int unsigned SIZE = 10
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      ctl;
    logic [SIZE-1:0] in1;
    logic [SIZE-1:0] in2;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] out;
    logic            carry_out;
    logic            overflow;
    logic            negative;
    logic            zero;

    modport master (
        output in_valid, ctl, in1, in2, out_ready,
        input  in_ready, out_valid, out, carry_out, overflow, negative, zero
    );

    modport slave (
        input  in_valid, ctl, in1, in2, out_ready,
        output in_ready, out_valid, out, carry_out, overflow, negative, zero
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle ops plus an iterative shift-add multiplier,
// with registered result/flags and valid/ready handshakes on both sides.
module alu_mc #(
    parameter int unsigned SIZE = 10
) (
    input  logic     clk,
    input  logic     rst,
    alu_mc_if.slave  bus
);
    localparam int unsigned CW  = $clog2(SIZE + 1);
    localparam int unsigned MSB = SIZE - 1;

    localparam logic [3:0] OP_PASS = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_SHR  = 4'b0110;
    localparam logic [3:0] OP_SAR  = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b1011;
    localparam logic [3:0] OP_SLTU = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;

    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] mcand_q, mcand_d;
    logic [SIZE-1:0] mplier_q, mplier_d;
    logic [SIZE-1:0] acc_q, acc_d;
    logic [SIZE-1:0] out_q, out_d;
    logic            carry_q, carry_d;
    logic            ovf_q, ovf_d;
    logic            neg_q, neg_d;
    logic            zero_q, zero_d;
    logic            valid_q, valid_d;

    logic            in_ready_c;
    logic            accept_c;
    logic [SIZE:0]   sum;
    logic [SIZE:0]   diff;
    logic            add_ovf;
    logic            sub_ovf;
    logic            shamt_big;
    logic [SIZE-1:0] alu_res;
    logic            alu_c;
    logic            alu_v;
    logic [SIZE-1:0] mul_acc_nxt;

    assign in_ready_c = (state_q == S_IDLE) && (!valid_q || bus.out_ready);
    assign accept_c   = bus.in_valid && in_ready_c;

    // Single-cycle datapath evaluated on the request operands
    always_comb begin
        sum       = {1'b0, bus.in1} + {1'b0, bus.in2};
        diff      = {1'b0, bus.in1} - {1'b0, bus.in2};
        add_ovf   = (bus.in1[MSB] == bus.in2[MSB]) && (sum[MSB] != bus.in1[MSB]);
        sub_ovf   = (bus.in1[MSB] != bus.in2[MSB]) && (diff[MSB] != bus.in1[MSB]);
        shamt_big = (bus.in2 >= SIZE'(SIZE));
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        case (bus.ctl)
            OP_PASS: alu_res = bus.in1;
            OP_ADD: begin
                alu_res = sum[MSB:0];
                alu_c   = sum[SIZE];
                alu_v   = add_ovf;
            end
            OP_AND:  alu_res = bus.in1 & bus.in2;
            OP_SUB: begin
                alu_res = diff[MSB:0];
                alu_c   = diff[SIZE];
                alu_v   = sub_ovf;
            end
            OP_SHL:  alu_res = shamt_big ? '0 : (bus.in1 << bus.in2);
            OP_OR:   alu_res = bus.in1 | bus.in2;
            OP_SHR:  alu_res = shamt_big ? '0 : (bus.in1 >> bus.in2);
            OP_SAR:  alu_res = shamt_big ? {SIZE{bus.in1[MSB]}}
                                         : SIZE'($signed(bus.in1) >>> bus.in2);
            OP_XOR:  alu_res = bus.in1 ^ bus.in2;
            OP_NOR:  alu_res = ~(bus.in1 | bus.in2);
            OP_SLT:  alu_res = {{(SIZE-1){1'b0}}, diff[MSB] ^ sub_ovf};
            OP_SLTU: alu_res = {{(SIZE-1){1'b0}}, diff[SIZE]};
            default: alu_res = '0;
        endcase
    end

    assign mul_acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Next-state and result/flag update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        out_d    = out_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        neg_d    = neg_q;
        zero_d   = zero_q;
        valid_d  = valid_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (bus.ctl == OP_MUL) begin
                        mcand_d  = bus.in1;
                        mplier_d = bus.in2;
                        acc_d    = '0;
                        cnt_d    = '0;
                        valid_d  = 1'b0;
                        state_d  = S_MUL;
                    end else begin
                        out_d   = alu_res;
                        carry_d = alu_c;
                        ovf_d   = alu_v;
                        neg_d   = alu_res[MSB];
                        zero_d  = (alu_res == '0);
                        valid_d = 1'b1;
                    end
                end else if (valid_q && bus.out_ready) begin
                    valid_d = 1'b0;
                end
            end
            S_MUL: begin
                acc_d    = mul_acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(SIZE - 1)) begin
                    out_d   = mul_acc_nxt;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    neg_d   = mul_acc_nxt[MSB];
                    zero_d  = (mul_acc_nxt == '0);
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            out_q    <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid_q;
    assign bus.out       = out_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.negative  = neg_q;
    assign bus.zero      = zero_q;
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the pipelined datapath's execute stage. It replaces the purely combinational ALU. It adds:
- registered results and a full flag set (zero, carry, overflow, negative);
- variable-amount and arithmetic shifts, plus XOR, NOR, SLT and SLTU;
- an iterative shift-add multiplier;
- valid/ready handshakes on input and output, so the pipeline can stall around multi-cycle operations.

## Interface
Parameters:
- SIZE, 10: operand and result width in bits (SIZE ≥ 4).
- CW, $clog2(SIZE+1): multiplier iteration counter width. Local, derived.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- ctl  in  4  operation select, sampled on accept.
- in1, in2  in  SIZE  operands, sampled on accept.
- out_valid  out  1  out and flags hold a valid result.
- out_ready  in  1  consumer takes the result this cycle.
- out  out  SIZE  registered result.
- carry_out, overflow, negative, zero  out  1 each  registered flags.

## Operation
- ctl encoding (width-agnostic):
  - 0000: pass in1.
  - 0001: add.
  - 0010: and.
  - 0011: sub (in1-in2).
  - 0100: logical shift left by in2.
  - 0101: or.
  - 0110: logical shift right by in2.
  - 0111: result 0 (branch).
  - 1000: arithmetic shift right by in2.
  - 1001: xor.
  - 1010: nor.
  - 1011: signed set-less-than.
  - 1100: unsigned set-less-than.
  - 1101: multiply, low SIZE bits (multi-cycle).
  - 1110, 1111: result 0.
- Shift amount is the full unsigned value of in2.
  - Amount ≥ SIZE: shl and shr give 0; sar gives SIZE copies of in1[SIZE-1].
- SLT/SLTU result is {SIZE-1 zeros, bit}.
  - SLT bit: (in1 - in2) sign XOR sub overflow.
  - SLTU bit: borrow of in1 - in2.
- carry_out:
  - add: bit SIZE of in1+in2.
  - sub: borrow, i.e. 1 when in1 < in2 unsigned.
  - all other ops: 0.
- overflow:
  - add: operand signs equal and result sign differs.
  - sub: operand signs differ and result sign differs from in1.
  - all other ops: 0.
- zero = (out == 0). negative = out[SIZE-1]. Both are computed on the registered result, for every op.
- State machine:
  - IDLE: in_ready = !out_valid || out_ready.
    - Accept (in_valid && in_ready) of a non-multiply op: result and flags registered at that edge; out_valid=1.
    - Accept of ctl=1101: latch multiplicand and multiplier, clear accumulator and counter, go to MUL, out_valid=0.
  - MUL: in_ready=0. Each edge:
    - if multiplier LSB is 1, add the multiplicand to the accumulator (mod 2^SIZE);
    - shift multiplicand left and multiplier right;
    - counter++.
    - On the SIZE-th iteration, write the final product to out, set flags (carry/overflow 0), set out_valid=1, return to IDLE.
- Output hold: while out_valid && !out_ready, out, flags and out_valid are frozen and no new request is accepted.
- Output release: an out_ready handshake with no simultaneous accept clears out_valid; out keeps its last value.
- Simultaneous: in IDLE, output handshake and new accept in the same cycle is legal. The new result replaces the old; out_valid stays 1.
- Reset, asserted at any time, including mid-MUL:
  - state IDLE, counter 0;
  - out=0, all flags 0, out_valid=0;
  - in_ready=1 while in IDLE with out_valid=0;
  - any in-flight multiply is discarded.

## Timing
- Non-multiply latency is 1 cycle: accept at edge k, result visible after edge k. Throughput is 1 op per cycle when out_ready=1.
- Multiply latency is SIZE cycles: accept at edge k, out_valid rises after edge k+SIZE. The next request can be accepted at edge k+SIZE+1 at the earliest.
- in_ready is combinational from state, out_valid and out_ready. There are no combinational paths from in_valid, ctl, in1 or in2 to any output.
- All arithmetic is modulo 2^SIZE, unsigned unless stated signed.

## Test plan
Scenarios use SIZE=10.
- Reset: hold rst mid-stimulus -> out=0x000, all flags 0, out_valid=0, in_ready=1, asynchronously without a clock edge.
- Add and sub:
  - add 0x3FF+0x001 -> out 0x000, carry_out 1, zero 1, overflow 0, one cycle after accept;
  - add 0x1FF+0x001 -> out 0x200, overflow 1, negative 1;
  - sub 0x200-0x001 -> out 0x1FF, overflow 1.
- Shifts and compares:
  - sar 0x200 by 3 -> 0x3C0;
  - shl 0x001 by 12 -> 0x000;
  - sar 0x2AA by 15 -> 0x3FF;
  - SLT 0x3FF,0x001 -> 0x001;
  - SLTU 0x3FF,0x001 -> 0x000.
- Multiply: 25 × 20 -> out 0x1F4, out_valid exactly 10 cycles after accept, in_ready 0 throughout MUL. Also 0x3FF × 0x3FF -> 0x001.
- Backpressure and overlap:
  - out_ready low for 3 cycles after a result -> out and flags stable, in_ready 0;
  - raise out_ready with in_valid high -> new op accepted that same edge, out_valid stays 1.
- Reset mid-multiply: assert rst 4 cycles into MUL -> out_valid 0, state IDLE. A following add 2+3 yields 0x005 after 1 cycle.
